// File: rtl/mcyc_ctrl_if.sv
// mcyc_ctrl_if: bundle between the multicycle controller and the datapath /
// memory-IO side.
//   Inst_in, zero, overflow, MIO_ready : datapath/bus -> controller
//   MemRead .. retire                  : controller -> datapath/bus
// The master modport is the controller's view; slave is the datapath's view.
interface mcyc_ctrl_if;
  logic [31:0] Inst_in;
  logic        zero;
  logic        overflow;
  logic        MIO_ready;

  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        IorD;
  logic        CPU_MIO;
  logic        RegWrite;
  logic        ALUSrcA;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;
  logic [1:0]  RegDst;
  logic [1:0]  MemtoReg;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic [2:0]  ALU_operation;
  logic [4:0]  state_out;
  logic        trap;
  logic [1:0]  trap_cause;
  logic        retire;

  modport master (
    input  Inst_in, zero, overflow, MIO_ready,
    output MemRead, MemWrite, IRWrite, IorD, CPU_MIO,
    output RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch,
    output RegDst, MemtoReg, ALUSrcB, PCSource,
    output ALU_operation, state_out, trap, trap_cause, retire
  );

  modport slave (
    output Inst_in, zero, overflow, MIO_ready,
    input  MemRead, MemWrite, IRWrite, IorD, CPU_MIO,
    input  RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch,
    input  RegDst, MemtoReg, ALUSrcB, PCSource,
    input  ALU_operation, state_out, trap, trap_cause, retire
  );
endinterface

// File: rtl/mcyc_ctrl.sv
// mcyc_ctrl: multicycle control unit for the MIPS-subset CPU.
// Sequences IF/ID/EX/MEM/WB, inserts wait states on MIO_ready, traps on bus
// timeout, illegal opcode and (optionally) signed overflow.
// Ports:
//   clk    : clock
//   reset  : asynchronous, active-high
//   bus    : mcyc_ctrl_if.master (IR contents, ALU flags, MIO_ready in;
//            memory/datapath controls, state_out, trap, trap_cause, retire out)
// Parameters:
//   TIMEOUT  : wait cycles allowed on MIO_ready before a timeout trap
//   TO_W     : wait counter width
//   TRAP_OVF : 1 = signed overflow on add/sub/addi traps
module mcyc_ctrl #(
  parameter int TIMEOUT  = 15,
  parameter int TO_W     = 4,
  parameter int TRAP_OVF = 1
) (
  input  logic         clk,
  input  logic         reset,
  mcyc_ctrl_if.master  bus
);

  typedef enum logic [4:0] {
    S_IF   = 5'd0,
    S_ID   = 5'd1,
    S_MA   = 5'd2,
    S_MRD  = 5'd3,
    S_LWB  = 5'd4,
    S_MWR  = 5'd5,
    S_REX  = 5'd6,
    S_RWB  = 5'd7,
    S_BEQ  = 5'd8,
    S_J    = 5'd9,
    S_IEX  = 5'd10,
    S_IWB  = 5'd11,
    S_LUI  = 5'd12,
    S_BNE  = 5'd13,
    S_JR   = 5'd14,
    S_JAL  = 5'd15,
    S_TRAP = 5'd16
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_JR  = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;
  localparam logic [1:0] CAUSE_OVF     = 2'b11;

  localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  // R-type funct -> ALU op; unknown functs fall back to ADD.
  function automatic logic [2:0] rex_alu_op(input logic [5:0] funct);
    case (funct)
      F_ADD:   rex_alu_op = ALU_ADD;
      F_SUB:   rex_alu_op = ALU_SUB;
      F_AND:   rex_alu_op = ALU_AND;
      F_OR:    rex_alu_op = ALU_OR;
      F_XOR:   rex_alu_op = ALU_XOR;
      F_NOR:   rex_alu_op = ALU_NOR;
      F_SLT:   rex_alu_op = ALU_SLT;
      F_SRL:   rex_alu_op = ALU_SRL;
      default: rex_alu_op = ALU_ADD;
    endcase
  endfunction

  // I-type opcode -> ALU op.
  function automatic logic [2:0] iex_alu_op(input logic [5:0] opcode);
    case (opcode)
      OP_ADDI: iex_alu_op = ALU_ADD;
      OP_ANDI: iex_alu_op = ALU_AND;
      OP_ORI:  iex_alu_op = ALU_OR;
      OP_XORI: iex_alu_op = ALU_XOR;
      OP_SLTI: iex_alu_op = ALU_SLT;
      default: iex_alu_op = ALU_ADD;
    endcase
  endfunction

  state_t          state_r;
  state_t          state_next_s;
  logic [TO_W-1:0] wait_cnt_r;
  logic [TO_W-1:0] wait_cnt_next_s;
  logic [1:0]      trap_cause_r;
  logic [1:0]      cause_next_s;
  logic [5:0]      opcode_s;
  logic [5:0]      funct_s;
  logic            timeout_hit_s;
  logic            ovf_en_s;
  logic            in_wait_s;

  assign opcode_s = bus.Inst_in[31:26];
  assign funct_s  = bus.Inst_in[5:0];

  // Timeout fires on the cycle whose increment would reach TIMEOUT; a
  // simultaneous MIO_ready wins.
  assign timeout_hit_s = (!bus.MIO_ready) && (wait_cnt_r == CNT_LAST);
  assign ovf_en_s      = (TRAP_OVF != 0) && bus.overflow;
  assign in_wait_s     = (state_r == S_IF) || (state_r == S_MRD) || (state_r == S_MWR);

  // State, wait counter and latched trap cause.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IF;
      wait_cnt_r   <= '0;
      trap_cause_r <= CAUSE_NONE;
    end else begin
      state_r    <= state_next_s;
      wait_cnt_r <= wait_cnt_next_s;
      if ((state_next_s == S_TRAP) && (state_r != S_TRAP)) begin
        trap_cause_r <= cause_next_s;
      end else begin
        trap_cause_r <= trap_cause_r;
      end
    end
  end

  // Next-state and trap cause selection.
  always_comb begin
    state_next_s = state_r;
    cause_next_s = CAUSE_NONE;
    case (state_r)
      S_IF: begin
        if (bus.MIO_ready) begin
          state_next_s = S_ID;
        end else if (timeout_hit_s) begin
          state_next_s = S_TRAP;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          state_next_s = S_IF;
        end
      end
      S_ID: begin
        case (opcode_s)
          OP_RTYPE: state_next_s = (funct_s == F_JR) ? S_JR : S_REX;
          OP_LW,
          OP_SW:    state_next_s = S_MA;
          OP_BEQ:   state_next_s = S_BEQ;
          OP_BNE:   state_next_s = S_BNE;
          OP_J:     state_next_s = S_J;
          OP_JAL:   state_next_s = S_JAL;
          OP_ADDI,
          OP_ANDI,
          OP_ORI,
          OP_XORI,
          OP_SLTI:  state_next_s = S_IEX;
          OP_LUI:   state_next_s = S_LUI;
          default: begin
            state_next_s = S_TRAP;
            cause_next_s = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MA: begin
        if (opcode_s == OP_LW) begin
          state_next_s = S_MRD;
        end else begin
          state_next_s = S_MWR;
        end
      end
      S_MRD, S_MWR: begin
        if (bus.MIO_ready) begin
          state_next_s = (state_r == S_MRD) ? S_LWB : S_IF;
        end else if (timeout_hit_s) begin
          state_next_s = S_TRAP;
          cause_next_s = CAUSE_TIMEOUT;
        end else begin
          state_next_s = state_r;
        end
      end
      S_REX: begin
        if (ovf_en_s && ((funct_s == F_ADD) || (funct_s == F_SUB))) begin
          state_next_s = S_TRAP;
          cause_next_s = CAUSE_OVF;
        end else begin
          state_next_s = S_RWB;
        end
      end
      S_IEX: begin
        if (ovf_en_s && (opcode_s == OP_ADDI)) begin
          state_next_s = S_TRAP;
          cause_next_s = CAUSE_OVF;
        end else begin
          state_next_s = S_IWB;
        end
      end
      S_LWB, S_RWB, S_IWB, S_LUI,
      S_BEQ, S_BNE, S_J, S_JR, S_JAL: state_next_s = S_IF;
      S_TRAP:  state_next_s = S_TRAP;
      default: state_next_s = S_IF;
    endcase
  end

  // Wait counter: any state change clears it, which covers entry into every
  // wait state; it counts only while stalled in a wait state.
  always_comb begin
    wait_cnt_next_s = wait_cnt_r;
    if (state_next_s != state_r) begin
      wait_cnt_next_s = '0;
    end else if (in_wait_s && !bus.MIO_ready) begin
      wait_cnt_next_s = wait_cnt_r + CNT_ONE;
    end else begin
      wait_cnt_next_s = wait_cnt_r;
    end
  end

  logic       mem_read_s, mem_write_s, ir_write_s, iord_s, cpu_mio_s;
  logic       reg_write_s, alu_src_a_s, pc_write_s, pc_write_cond_s, branch_s;
  logic [1:0] reg_dst_s, mem_to_reg_s, alu_src_b_s, pc_source_s;
  logic [2:0] alu_op_s;
  logic       trap_s, retire_s;

  // Per-state datapath controls, decoded from the current state and inputs.
  always_comb begin
    mem_read_s      = 1'b0;
    mem_write_s     = 1'b0;
    ir_write_s      = 1'b0;
    iord_s          = 1'b0;
    cpu_mio_s       = 1'b0;
    reg_write_s     = 1'b0;
    alu_src_a_s     = 1'b0;
    pc_write_s      = 1'b0;
    pc_write_cond_s = 1'b0;
    branch_s        = 1'b0;
    reg_dst_s       = 2'd0;
    mem_to_reg_s    = 2'd0;
    alu_src_b_s     = 2'd0;
    pc_source_s     = 2'd0;
    alu_op_s        = ALU_ADD;
    trap_s          = 1'b0;
    retire_s        = 1'b0;
    case (state_r)
      S_IF: begin
        mem_read_s  = 1'b1;
        cpu_mio_s   = 1'b1;
        alu_src_b_s = 2'd1;
        ir_write_s  = bus.MIO_ready;
        pc_write_s  = bus.MIO_ready;
      end
      S_ID:  alu_src_b_s = 2'd3;
      S_MA: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
      end
      S_MRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        cpu_mio_s  = 1'b1;
      end
      S_LWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 2'd1;
        retire_s     = 1'b1;
      end
      S_MWR: begin
        mem_write_s = 1'b1;
        iord_s      = 1'b1;
        cpu_mio_s   = 1'b1;
        retire_s    = bus.MIO_ready;
      end
      S_REX: begin
        alu_src_a_s = 1'b1;
        alu_op_s    = rex_alu_op(funct_s);
      end
      S_RWB: begin
        reg_write_s = 1'b1;
        reg_dst_s   = 2'd1;
        retire_s    = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alu_src_a_s     = 1'b1;
        alu_op_s        = ALU_SUB;
        pc_write_cond_s = 1'b1;
        pc_source_s     = 2'd1;
        branch_s        = (state_r == S_BEQ);
        retire_s        = 1'b1;
      end
      S_J: begin
        pc_write_s  = 1'b1;
        pc_source_s = 2'd2;
        retire_s    = 1'b1;
      end
      S_IEX: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = 2'd2;
        alu_op_s    = iex_alu_op(opcode_s);
      end
      S_IWB: begin
        reg_write_s = 1'b1;
        retire_s    = 1'b1;
      end
      S_LUI: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 2'd2;
        retire_s     = 1'b1;
      end
      S_JR: begin
        alu_src_a_s = 1'b1;
        pc_write_s  = 1'b1;
        pc_source_s = 2'd3;
        retire_s    = 1'b1;
      end
      S_JAL: begin
        pc_write_s   = 1'b1;
        pc_source_s  = 2'd2;
        reg_write_s  = 1'b1;
        mem_to_reg_s = 2'd3;
        reg_dst_s    = 2'd2;
        retire_s     = 1'b1;
      end
      S_TRAP: begin
        trap_s   = 1'b1;
        alu_op_s = 3'b000;
      end
      default: begin
        trap_s   = 1'b0;
        alu_op_s = ALU_ADD;
      end
    endcase
  end

  assign bus.MemRead       = mem_read_s;
  assign bus.MemWrite      = mem_write_s;
  assign bus.IRWrite       = ir_write_s;
  assign bus.IorD          = iord_s;
  assign bus.CPU_MIO       = cpu_mio_s;
  assign bus.RegWrite      = reg_write_s;
  assign bus.ALUSrcA       = alu_src_a_s;
  assign bus.PCWrite       = pc_write_s;
  assign bus.PCWriteCond   = pc_write_cond_s;
  assign bus.Branch        = branch_s;
  assign bus.RegDst        = reg_dst_s;
  assign bus.MemtoReg      = mem_to_reg_s;
  assign bus.ALUSrcB       = alu_src_b_s;
  assign bus.PCSource      = pc_source_s;
  assign bus.ALU_operation = alu_op_s;
  assign bus.state_out     = state_r;
  assign bus.trap          = trap_s;
  assign bus.trap_cause    = trap_cause_r;
  assign bus.retire        = retire_s;

endmodule

// File: tb/tb_mcyc_ctrl.sv
// tb_mcyc_ctrl: directed self-checking bench for mcyc_ctrl. A second
// instance with TRAP_OVF=0 runs in lockstep on the same inputs.
module tb_mcyc_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mcyc_ctrl_if bus();
  mcyc_ctrl_if bus_n();

  assign bus_n.Inst_in   = bus.Inst_in;
  assign bus_n.zero      = bus.zero;
  assign bus_n.overflow  = bus.overflow;
  assign bus_n.MIO_ready = bus.MIO_ready;

  mcyc_ctrl #(.TIMEOUT(15), .TO_W(4), .TRAP_OVF(1)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  mcyc_ctrl #(.TIMEOUT(15), .TO_W(4), .TRAP_OVF(0)) dut_nov (
    .clk(clk), .reset(reset), .bus(bus_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.MIO_ready = 1'b0;
    bus.overflow  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.MIO_ready = 1'b0;
    tick();
    checks++; if (bus.state_out !== 5'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.state_out); end
    checks++; if (bus.MemRead !== 1'b1 || bus.CPU_MIO !== 1'b1 || bus.ALUSrcB !== 2'd1) begin errors++; $display("FAIL reset_if_ctrl got MemRead=%0b CPU_MIO=%0b ALUSrcB=%0d exp 1 1 1", bus.MemRead, bus.CPU_MIO, bus.ALUSrcB); end
    checks++; if (bus.IRWrite !== 1'b0 || bus.PCWrite !== 1'b0) begin errors++; $display("FAIL reset_no_ready got IRWrite=%0b PCWrite=%0b exp 0 0", bus.IRWrite, bus.PCWrite); end
    checks++; if (bus.trap_cause !== 2'b00 || bus.trap !== 1'b0 || bus.retire !== 1'b0) begin errors++; $display("FAIL reset_trap got cause=%0b trap=%0b retire=%0b exp 00 0 0", bus.trap_cause, bus.trap, bus.retire); end
    do_reset();
  endtask

  task automatic test_add();
    logic [4:0] exp_st [5];
    logic       exp_rt [5];
    int         pulses;
    exp_st = '{5'd0, 5'd1, 5'd6, 5'd7, 5'd0};
    exp_rt = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    pulses = 0;
    bus.Inst_in = 32'h0022_1820;
    bus.MIO_ready = 1'b1;
    #1;
    checks++; if (bus.IRWrite !== 1'b1 || bus.PCWrite !== 1'b1) begin errors++; $display("FAIL add_if_ready got IRWrite=%0b PCWrite=%0b exp 1 1", bus.IRWrite, bus.PCWrite); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.state_out !== exp_st[i] || bus.retire !== exp_rt[i]) begin errors++; $display("FAIL add_seq[%0d] got state=%0d retire=%0b exp %0d %0b", i, bus.state_out, bus.retire, exp_st[i], exp_rt[i]); end
      if (bus.retire === 1'b1) pulses++;
      if (i == 2) begin
        checks++; if (bus.ALU_operation !== 3'b010 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'd0) begin errors++; $display("FAIL add_rex got op=%0b A=%0b B=%0d exp 010 1 0", bus.ALU_operation, bus.ALUSrcA, bus.ALUSrcB); end
      end
      if (i == 3) begin
        checks++; if (bus.RegWrite !== 1'b1 || bus.RegDst !== 2'd1) begin errors++; $display("FAIL add_rwb got RegWrite=%0b RegDst=%0d exp 1 1", bus.RegWrite, bus.RegDst); end
      end
      if (i < 4) tick();
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL add_retire_count got %0d exp 1", pulses); end
  endtask

  task automatic test_lw_wait();
    int memrd;
    do_reset();
    bus.Inst_in = 32'h8C22_0004;
    bus.MIO_ready = 1'b1;
    tick();
    bus.MIO_ready = 1'b0;
    tick();
    #1;
    checks++; if (bus.state_out !== 5'd2 || bus.ALUSrcA !== 1'b1 || bus.ALUSrcB !== 2'd2) begin errors++; $display("FAIL lw_ma got state=%0d A=%0b B=%0d exp 2 1 2", bus.state_out, bus.ALUSrcA, bus.ALUSrcB); end
    tick();
    memrd = 0;
    for (int i = 0; i < 4; i++) begin
      bus.MIO_ready = (i == 3) ? 1'b1 : 1'b0;
      #1;
      if (bus.state_out === 5'd3 && bus.MemRead === 1'b1 && bus.IorD === 1'b1) memrd++;
      tick();
    end
    checks++; if (memrd != 4) begin errors++; $display("FAIL lw_mrd_cycles got %0d exp 4", memrd); end
    checks++; if (bus.state_out !== 5'd4 || bus.MemtoReg !== 2'd1 || bus.RegWrite !== 1'b1 || bus.retire !== 1'b1) begin errors++; $display("FAIL lw_lwb got state=%0d MemtoReg=%0d RegWrite=%0b retire=%0b exp 4 1 1 1", bus.state_out, bus.MemtoReg, bus.RegWrite, bus.retire); end
    tick();
    checks++; if (bus.state_out !== 5'd0) begin errors++; $display("FAIL lw_total_8 got state=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_sw_timeout();
    int n;
    do_reset();
    bus.Inst_in = 32'hAC22_0004;
    bus.MIO_ready = 1'b1;
    tick();
    bus.MIO_ready = 1'b0;
    tick();
    tick();
    checks++; if (bus.state_out !== 5'd5 || bus.MemWrite !== 1'b1 || bus.retire !== 1'b0) begin errors++; $display("FAIL sw_mwr got state=%0d MemWrite=%0b retire=%0b exp 5 1 0", bus.state_out, bus.MemWrite, bus.retire); end
    n = 0;
    while (bus.state_out === 5'd5 && n < 40) begin
      n++;
      tick();
    end
    checks++; if (n != 15) begin errors++; $display("FAIL sw_wait_cycles got %0d exp 15", n); end
    checks++; if (bus.state_out !== 5'd16 || bus.trap !== 1'b1 || bus.trap_cause !== 2'b01) begin errors++; $display("FAIL sw_timeout_trap got state=%0d trap=%0b cause=%0b exp 16 1 01", bus.state_out, bus.trap, bus.trap_cause); end
    checks++; if (bus.MemWrite !== 1'b0 || bus.CPU_MIO !== 1'b0) begin errors++; $display("FAIL sw_trap_quiet got MemWrite=%0b CPU_MIO=%0b exp 0 0", bus.MemWrite, bus.CPU_MIO); end
  endtask

  task automatic test_illegal();
    int left;
    do_reset();
    bus.Inst_in = 32'hFC00_0000;
    bus.MIO_ready = 1'b1;
    tick();
    checks++; if (bus.state_out !== 5'd1 || bus.ALUSrcB !== 2'd3) begin errors++; $display("FAIL ill_id got state=%0d B=%0d exp 1 3", bus.state_out, bus.ALUSrcB); end
    tick();
    checks++; if (bus.state_out !== 5'd16 || bus.trap_cause !== 2'b10 || bus.MemRead !== 1'b0) begin errors++; $display("FAIL ill_trap got state=%0d cause=%0b MemRead=%0b exp 16 10 0", bus.state_out, bus.trap_cause, bus.MemRead); end
    left = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.state_out !== 5'd16 || bus.trap !== 1'b1) left++;
    end
    checks++; if (left != 0) begin errors++; $display("FAIL ill_hold got %0d cycles out of trap exp 0", left); end
    reset = 1'b1;
    #1;
    checks++; if (bus.state_out !== 5'd0 || bus.trap_cause !== 2'b00 || bus.trap !== 1'b0) begin errors++; $display("FAIL ill_reset got state=%0d cause=%0b trap=%0b exp 0 00 0", bus.state_out, bus.trap_cause, bus.trap); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_addi_ovf();
    do_reset();
    bus.Inst_in = {6'b001000, 5'd1, 5'd2, 16'h7FFF};
    bus.MIO_ready = 1'b1;
    tick();
    tick();
    bus.overflow = 1'b1;
    #1;
    checks++; if (bus.state_out !== 5'd10 || bus.ALU_operation !== 3'b010 || bus.ALUSrcB !== 2'd2) begin errors++; $display("FAIL addi_iex got state=%0d op=%0b B=%0d exp 10 010 2", bus.state_out, bus.ALU_operation, bus.ALUSrcB); end
    tick();
    bus.overflow = 1'b0;
    checks++; if (bus.state_out !== 5'd16 || bus.trap_cause !== 2'b11 || bus.RegWrite !== 1'b0) begin errors++; $display("FAIL addi_ovf_trap got state=%0d cause=%0b RegWrite=%0b exp 16 11 0", bus.state_out, bus.trap_cause, bus.RegWrite); end
    checks++; if (bus_n.state_out !== 5'd11 || bus_n.RegWrite !== 1'b1 || bus_n.RegDst !== 2'd0 || bus_n.trap_cause !== 2'b00) begin errors++; $display("FAIL addi_noovf_iwb got state=%0d RegWrite=%0b RegDst=%0d cause=%0b exp 11 1 0 00", bus_n.state_out, bus_n.RegWrite, bus_n.RegDst, bus_n.trap_cause); end
  endtask

  task automatic test_sub_ovf();
    do_reset();
    bus.Inst_in = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100010};
    bus.MIO_ready = 1'b1;
    tick();
    tick();
    bus.overflow = 1'b1;
    #1;
    checks++; if (bus.state_out !== 5'd6 || bus.ALU_operation !== 3'b110) begin errors++; $display("FAIL sub_rex got state=%0d op=%0b exp 6 110", bus.state_out, bus.ALU_operation); end
    tick();
    bus.overflow = 1'b0;
    checks++; if (bus.state_out !== 5'd16 || bus.trap_cause !== 2'b11) begin errors++; $display("FAIL sub_ovf_trap got state=%0d cause=%0b exp 16 11", bus.state_out, bus.trap_cause); end
    checks++; if (bus_n.state_out !== 5'd7) begin errors++; $display("FAIL sub_noovf_rwb got state=%0d exp 7", bus_n.state_out); end
  endtask

  task automatic test_ori_slt();
    do_reset();
    bus.Inst_in = {6'b001101, 5'd1, 5'd2, 16'h00F0};
    bus.MIO_ready = 1'b1;
    tick();
    tick();
    checks++; if (bus.state_out !== 5'd10 || bus.ALU_operation !== 3'b001) begin errors++; $display("FAIL ori_iex got state=%0d op=%0b exp 10 001", bus.state_out, bus.ALU_operation); end
    tick();
    checks++; if (bus.state_out !== 5'd11 || bus.RegWrite !== 1'b1 || bus.retire !== 1'b1) begin errors++; $display("FAIL ori_iwb got state=%0d RegWrite=%0b retire=%0b exp 11 1 1", bus.state_out, bus.RegWrite, bus.retire); end
    tick();
    bus.Inst_in = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010};
    tick();
    tick();
    checks++; if (bus.state_out !== 5'd6 || bus.ALU_operation !== 3'b111) begin errors++; $display("FAIL slt_rex got state=%0d op=%0b exp 6 111", bus.state_out, bus.ALU_operation); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.MIO_ready = 1'b1;
    bus.Inst_in = {6'b000101, 5'd1, 5'd2, 16'h0010};
    tick();
    tick();
    checks++; if (bus.state_out !== 5'd13 || bus.Branch !== 1'b0 || bus.PCWriteCond !== 1'b1 || bus.ALU_operation !== 3'b110 || bus.PCSource !== 2'd1) begin errors++; $display("FAIL bne got state=%0d Branch=%0b PCWC=%0b op=%0b PCS=%0d exp 13 0 1 110 1", bus.state_out, bus.Branch, bus.PCWriteCond, bus.ALU_operation, bus.PCSource); end
    tick();
    checks++; if (bus.state_out !== 5'd0) begin errors++; $display("FAIL bne_3cyc got state=%0d exp 0", bus.state_out); end
    bus.Inst_in = {6'b000000, 5'd4, 5'd0, 5'd0, 5'd0, 6'b001000};
    tick();
    tick();
    checks++; if (bus.state_out !== 5'd14 || bus.PCSource !== 2'd3 || bus.PCWrite !== 1'b1 || bus.ALUSrcA !== 1'b1) begin errors++; $display("FAIL jr got state=%0d PCS=%0d PCW=%0b A=%0b exp 14 3 1 1", bus.state_out, bus.PCSource, bus.PCWrite, bus.ALUSrcA); end
    tick();
    checks++; if (bus.state_out !== 5'd0) begin errors++; $display("FAIL jr_3cyc got state=%0d exp 0", bus.state_out); end
    bus.Inst_in = {6'b000011, 26'h0000040};
    tick();
    tick();
    checks++; if (bus.state_out !== 5'd15 || bus.RegDst !== 2'd2 || bus.MemtoReg !== 2'd3 || bus.PCSource !== 2'd2 || bus.RegWrite !== 1'b1) begin errors++; $display("FAIL jal got state=%0d RegDst=%0d MtoR=%0d PCS=%0d RW=%0b exp 15 2 3 2 1", bus.state_out, bus.RegDst, bus.MemtoReg, bus.PCSource, bus.RegWrite); end
    tick();
    checks++; if (bus.state_out !== 5'd0) begin errors++; $display("FAIL jal_3cyc got state=%0d exp 0", bus.state_out); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    bus.Inst_in = 32'hAC22_0004;
    bus.MIO_ready = 1'b1;
    tick();
    bus.MIO_ready = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (bus.state_out !== 5'd5 || bus.MemWrite !== 1'b1) begin errors++; $display("FAIL mid_mwr got state=%0d MemWrite=%0b exp 5 1", bus.state_out, bus.MemWrite); end
    reset = 1'b1;
    #1;
    checks++; if (bus.MemWrite !== 1'b0 || bus.state_out !== 5'd0) begin errors++; $display("FAIL mid_reset got MemWrite=%0b state=%0d exp 0 0", bus.MemWrite, bus.state_out); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b1;
    checks = 0;
    errors = 0;
    bus.Inst_in = 32'h0000_0000;
    bus.zero = 1'b0;
    bus.overflow = 1'b0;
    bus.MIO_ready = 1'b0;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw_timeout();
    test_illegal();
    test_addi_ovf();
    test_sub_ovf();
    test_ori_slt();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mcyc_ctrl.md
# mcyc_ctrl

Parametrised multicycle control unit for the MIPS-subset CPU. It sequences fetch, decode, execute, memory and write-back, and drives every datapath mux and enable. Compared with the previous controller it adds three things: MIO_ready wait states on every memory access, a bus-timeout counter, and a trap state with a cause code for illegal opcodes, timeouts and (optionally) signed overflow. It sits beside the datapath and memory/IO bus, driven by the IR contents and the ALU flags.

## Interface
- TIMEOUT, 15: max cycles waiting on MIO_ready before a bus-timeout trap (1..2^TO_W-1)
- TO_W, 4: width of the wait counter
- TRAP_OVF, 1: 1 = overflow on add/sub/addi traps; 0 = overflow ignored
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- Inst_in  in  32  current IR contents
- zero, overflow  in  1  ALU flags
- MIO_ready  in  1  memory/IO access complete
- MemRead, MemWrite, IRWrite, IorD, CPU_MIO  out  1  memory-side controls
- RegWrite, ALUSrcA, PCWrite, PCWriteCond, Branch  out  1  datapath enables/selects
- RegDst, MemtoReg, ALUSrcB, PCSource  out  2  mux selects
- ALU_operation  out  3  ALU op code
- state_out  out  5  current state
- trap  out  1  high while in TRAP
- trap_cause  out  2  01 timeout, 10 illegal opcode, 11 overflow; 00 otherwise
- retire  out  1  one-cycle pulse on the last cycle of each completed instruction

## Operation
- Mux encodings:
  - ALUSrcA: 0 = PC, 1 = rs.
  - ALUSrcB: 0 = rt, 1 = 4, 2 = sext imm, 3 = sext imm<<2.
  - PCSource: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs.
  - MemtoReg: 0 = ALUOut, 1 = MDR, 2 = imm<<16, 3 = PC.
  - RegDst: 0 = rt, 1 = rd, 2 = 31.
- ALU codes: AND 000, OR 001, ADD 010, XOR 011, NOR 100, SRL 101, SUB 110, SLT 111.
- Per-state outputs (anything not listed is 0; ALU_operation defaults to ADD):
  - IF(0): MemRead, IorD=0, IRWrite, CPU_MIO, ALUSrcB=1, PCWrite. IRWrite and PCWrite are asserted only in the cycle MIO_ready=1.
  - ID(1): ALUSrcB=3.
  - MA(2): ALUSrcA=1, ALUSrcB=2.
  - MRD(3): MemRead, IorD, CPU_MIO.
  - LWB(4): RegWrite, MemtoReg=1, RegDst=0.
  - MWR(5): MemWrite, IorD, CPU_MIO.
  - REX(6): ALUSrcA=1, ALUSrcB=0, funct decode (100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT, 000010 SRL, other ADD).
  - RWB(7): RegWrite, RegDst=1.
  - BEQ(8): ALUSrcA=1, SUB, PCWriteCond, PCSource=1, Branch=1.
  - J(9): PCWrite, PCSource=2.
  - IEX(10): ALUSrcA=1, ALUSrcB=2, op decode (001000 ADD, 001100 AND, 001101 OR, 001110 XOR, 001010 SLT).
  - IWB(11): RegWrite, RegDst=0.
  - LUI(12): RegWrite, MemtoReg=2.
  - BNE(13): as BEQ but Branch=0.
  - JR(14): ALUSrcA=1, PCWrite, PCSource=3.
  - JAL(15): PCWrite, PCSource=2, RegWrite, MemtoReg=3, RegDst=2.
  - TRAP(16): trap=1, all other outputs 0.
- Transitions:
  - IF: go to ID on MIO_ready; otherwise stay.
  - ID, by opcode: 000000 → JR if funct=001000, else REX; 100011/101011 → MA; 000100 → BEQ; 000101 → BNE; 000010 → J; 000011 → JAL; 001000/001100/001101/001110/001010 → IEX; 001111 → LUI; any other opcode → TRAP with cause 10.
  - MA: lw → MRD, sw → MWR.
  - MRD: → LWB on MIO_ready.
  - MWR: → IF on MIO_ready.
  - REX → RWB; IEX → IWB.
  - Overflow trap: in REX (ADD/SUB) or IEX (addi), if TRAP_OVF=1 and overflow=1, go to TRAP with cause 11. Write-back is not performed.
  - LWB, RWB, IWB, LUI, BEQ, BNE, J, JR, JAL → IF.
  - TRAP holds until reset.
- Wait counter (TO_W bits):
  - Clears on entry to IF, MRD or MWR.
  - Increments each cycle the FSM stays in a wait state with MIO_ready=0.
  - If it reaches TIMEOUT with MIO_ready still 0, go to TRAP with cause 01.
  - MIO_ready=1 on the same cycle as the count reaching TIMEOUT counts as success, not a timeout.
- retire: 1 during the final state of each instruction. For MWR it is asserted only in the MIO_ready cycle.

## Timing
- Reset:
  - state = IF, counter = 0, trap_cause = 00.
  - Outputs take the IF values immediately, through the combinational decode.
- Outputs are a pure function of state, Inst_in, MIO_ready and overflow. trap_cause is registered on TRAP entry.
- Latency with zero wait states, counted from IF entry to the next IF entry:
  - J, JR, JAL, BEQ, BNE, LUI: 3 cycles.
  - R-type, I-type: 4 cycles.
  - sw: 4 cycles.
  - lw: 5 cycles.
  - Each wait cycle adds one cycle.
- Inst_in must be stable from ID until retire; it is sampled in ID, REX, IEX and MA.
- Asserting reset mid-access drops MemRead/MemWrite asynchronously; there is no partial completion.

## Test plan
- Reset, then `add` (0x00221820) with MIO_ready=1: states 0,1,6,7,0; RegWrite=1 and RegDst=1 in state 7; retire pulses once.
- `lw` (0x8C220004) with MIO_ready held low for 3 cycles in MRD: MemRead/IorD held for 4 cycles, then LWB with MemtoReg=1; total 8 cycles.
- `sw` with MIO_ready never high, TIMEOUT=15: exactly 15 wait cycles in MWR, then TRAP with trap_cause=01; MemWrite=0 afterwards.
- Opcode 0x3F in ID: TRAP with cause 10; stays there across 20 cycles; reset returns to IF.
- `addi` with overflow=1 in IEX: TRAP_OVF=1 → TRAP, cause 11, RegWrite never asserted; TRAP_OVF=0 → IWB, RegWrite=1.
- `bne`, `jr` (funct 001000), `jal`:
  - bne: Branch=0, PCWriteCond=1, ALU_operation=110.
  - jr: PCSource=3.
  - jal: RegDst=2, MemtoReg=3, PCSource=2; each takes 3 cycles.
